// File: rtl/prog_loader.sv
// Program loader: streams an instruction image then a data image into the memories, then runs the CPU.
// Optional watchdog on the RUN state is enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int IMEM_DEPTH     = 512,
  parameter int DMEM_DEPTH     = 1024,
  parameter int ADDR_STEP      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic        halt,
  output logic [31:0] imem_addr_ext,
  output logic [31:0] imem_wdata_ext,
  output logic        imem_wen_ext,
  output logic        imem_ren_ext,
  output logic [31:0] dmem_addr_ext,
  output logic [31:0] dmem_wdata_ext,
  output logic        dmem_wen_ext,
  output logic        dmem_ren_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, I_HDR, I_LOAD, D_HDR, D_LOAD, RUN, DONE, ERR} state_t;

  state_t      state, next_state;
  logic [10:0] cnt, tgt;
  logic        xfer, last_word, timeout_hit;

  assign s_ready      = (state == I_HDR) || (state == I_LOAD) || (state == D_HDR) || (state == D_LOAD);
  assign busy         = s_ready || (state == RUN);
  assign done         = (state == DONE);
  assign error        = (state == ERR);
  assign imem_ren_ext = 1'b0;
  assign dmem_ren_ext = 1'b0;
  assign xfer         = s_valid && s_ready;
  assign last_word    = (cnt == tgt - 11'd1);

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [31:0] run_cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)               run_cnt <= '0;
    else if (state != RUN)  run_cnt <= '0;
    else                    run_cnt <= run_cnt + 32'd1;
  end

  assign timeout_hit = (state == RUN) && (run_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = I_HDR;
      I_HDR:
        if (xfer) begin
          if (s_data > 32'(IMEM_DEPTH)) next_state = ERR;
          else if (s_data == 32'd0)     next_state = D_HDR;
          else                          next_state = I_LOAD;
        end
      I_LOAD:  if (xfer && last_word) next_state = D_HDR;
      D_HDR:
        if (xfer) begin
          if (s_data > 32'(DMEM_DEPTH)) next_state = ERR;
          else if (s_data == 32'd0)     next_state = RUN;
          else                          next_state = D_LOAD;
        end
      D_LOAD:  if (xfer && last_word) next_state = RUN;
      // halt wins over a simultaneous watchdog expiry
      RUN:
        if (halt)             next_state = DONE;
        else if (timeout_hit) next_state = ERR;
      DONE:    if (start) next_state = I_HDR;
      default: next_state = state;
    endcase
  end

  // Registered write port: strobe, address and data appear the cycle after the accepting edge.
  // cpu_enable lags RUN entry by one cycle so it never overlaps the final data write.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt            <= '0;
      tgt            <= '0;
      imem_wen_ext   <= 1'b0;
      imem_addr_ext  <= '0;
      imem_wdata_ext <= '0;
      dmem_wen_ext   <= 1'b0;
      dmem_addr_ext  <= '0;
      dmem_wdata_ext <= '0;
      cpu_enable     <= 1'b0;
    end else begin
      imem_wen_ext <= 1'b0;
      dmem_wen_ext <= 1'b0;
      cpu_enable   <= (state == RUN) && (next_state == RUN);
      case (state)
        I_HDR, D_HDR:
          if (xfer) begin
            tgt <= s_data[10:0];
            cnt <= '0;
          end
        I_LOAD:
          if (xfer) begin
            imem_wen_ext   <= 1'b1;
            imem_addr_ext  <= 32'(cnt) * 32'(ADDR_STEP);
            imem_wdata_ext <= s_data;
            cnt            <= last_word ? 11'd0 : cnt + 11'd1;
          end
        D_LOAD:
          if (xfer) begin
            dmem_wen_ext   <= 1'b1;
            dmem_addr_ext  <= 32'(cnt) * 32'(ADDR_STEP);
            dmem_wdata_ext <= s_data;
            cnt            <= last_word ? 11'd0 : cnt + 11'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, bubbles, zero headers, overflow, abort and run/watchdog.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        halt = 1'b0;
  logic [31:0] imem_addr_ext, imem_wdata_ext, dmem_addr_ext, dmem_wdata_ext;
  logic        imem_wen_ext, imem_ren_ext, dmem_wen_ext, dmem_ren_ext;
  logic        cpu_enable, busy, done, error;

  int checks = 0;
  int errs   = 0;
  int overlap_cnt = 0;
  int ren_cnt     = 0;

  logic [31:0] im_a[$], im_d[$], dm_a[$], dm_d[$];
  logic [31:0] iw[3];
  logic [31:0] dw[2];

  prog_loader #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .arst(arst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .halt(halt),
    .imem_addr_ext(imem_addr_ext), .imem_wdata_ext(imem_wdata_ext),
    .imem_wen_ext(imem_wen_ext), .imem_ren_ext(imem_ren_ext),
    .dmem_addr_ext(dmem_addr_ext), .dmem_wdata_ext(dmem_wdata_ext),
    .dmem_wen_ext(dmem_wen_ext), .dmem_ren_ext(dmem_ren_ext),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write strobes last one full cycle, so one sample per falling edge records each write once
  always @(negedge clk) begin
    if (!arst) begin
      if (imem_wen_ext) begin im_a.push_back(imem_addr_ext); im_d.push_back(imem_wdata_ext); end
      if (dmem_wen_ext) begin dm_a.push_back(dmem_addr_ext); dm_d.push_back(dmem_wdata_ext); end
      if ((imem_wen_ext || dmem_wen_ext) && cpu_enable) overlap_cnt++;
      if (imem_ren_ext || dmem_ren_ext) ren_cnt++;
    end
  end

  task automatic clear_q();
    im_a.delete(); im_d.delete(); dm_a.delete(); dm_d.delete();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Holds s_valid high until the word is accepted; returns 1ns after the accepting edge
  task automatic send(input logic [31:0] d);
    logic rdy;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    do begin
      rdy = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      checks++; errs++;
      $display("FAIL send_timeout word=%h s_ready=%b required 1", d, s_ready);
    end
  endtask

  task automatic send_gap(input logic [31:0] d);
    send(d);
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    #3;
    checks++;
    if ({imem_addr_ext, imem_wdata_ext, dmem_addr_ext, dmem_wdata_ext, imem_wen_ext, imem_ren_ext,
         dmem_wen_ext, dmem_ren_ext, cpu_enable, busy, done, error, s_ready} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got nonzero output vector required all 0");
    end
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, s_ready, done, error} !== 4'b0000) begin
      errs++; $display("FAIL idle_status got %b required 0000", {busy, s_ready, done, error});
    end
  endtask

  task automatic test_basic();
    clear_q();
    pulse_start();
    send(32'd3);
    for (int i = 0; i < 3; i++) send(iw[i]);
    send(32'd2);
    for (int i = 0; i < 2; i++) send(dw[i]);
    s_valid = 1'b0;
    checks++;
    if ({cpu_enable, dmem_wen_ext, dmem_addr_ext} !== {1'b0, 1'b1, 32'd4}) begin
      errs++; $display("FAIL basic_last_write cpu=%b wen=%b addr=%0d required 0 1 4",
                       cpu_enable, dmem_wen_ext, dmem_addr_ext);
    end
    @(posedge clk); #1;
    checks++;
    if ({cpu_enable, busy} !== 2'b11) begin
      errs++; $display("FAIL basic_cpu_rise cpu=%b busy=%b required 1 1", cpu_enable, busy);
    end
    checks++;
    if (im_a.size() != 3 || dm_a.size() != 2) begin
      errs++; $display("FAIL basic_write_count imem=%0d dmem=%0d required 3 2", im_a.size(), dm_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (im_a[i] !== 32'(i * 4) || im_d[i] !== iw[i]) begin
          errs++; $display("FAIL basic_imem[%0d] got %h@%0d required %h@%0d", i, im_d[i], im_a[i], iw[i], i * 4);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dm_a[i] !== 32'(i * 4) || dm_d[i] !== dw[i]) begin
          errs++; $display("FAIL basic_dmem[%0d] got %h@%0d required %h@%0d", i, dm_d[i], dm_a[i], dw[i], i * 4);
        end
      end
    end
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    checks++;
    if ({done, cpu_enable, busy} !== 3'b100) begin
      errs++; $display("FAIL basic_halt done/cpu/busy=%b required 100", {done, cpu_enable, busy});
    end
  endtask

  task automatic test_bubbles();
    clear_q();
    pulse_start();
    checks++;
    if ({done, busy} !== 2'b01) begin
      errs++; $display("FAIL reload_clears_done done/busy=%b required 01", {done, busy});
    end
    send_gap(32'd3);
    for (int i = 0; i < 3; i++) send_gap(iw[i]);
    send_gap(32'd2);
    for (int i = 0; i < 2; i++) send_gap(dw[i]);
    checks++;
    if (cpu_enable !== 1'b1) begin
      errs++; $display("FAIL bubble_cpu_enable got %b required 1", cpu_enable);
    end
    checks++;
    if (im_a.size() != 3 || dm_a.size() != 2) begin
      errs++; $display("FAIL bubble_write_count imem=%0d dmem=%0d required 3 2", im_a.size(), dm_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (im_a[i] !== 32'(i * 4) || im_d[i] !== iw[i]) begin
          errs++; $display("FAIL bubble_imem[%0d] got %h@%0d required %h@%0d", i, im_d[i], im_a[i], iw[i], i * 4);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dm_a[i] !== 32'(i * 4) || dm_d[i] !== dw[i]) begin
          errs++; $display("FAIL bubble_dmem[%0d] got %h@%0d required %h@%0d", i, dm_d[i], dm_a[i], dw[i], i * 4);
        end
      end
    end
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
  endtask

  task automatic test_zero_headers();
    clear_q();
    pulse_start();
    send(32'd0);
    send(32'd0);
    s_valid = 1'b0;
    checks++;
    if ({cpu_enable, busy, s_ready} !== 3'b010) begin
      errs++; $display("FAIL zero_run_entry cpu/busy/rdy=%b required 010", {cpu_enable, busy, s_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_enable !== 1'b1) begin
      errs++; $display("FAIL zero_cpu_rise got %b required 1", cpu_enable);
    end
`ifdef PROG_LOADER_TIMEOUT_EN
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ({cpu_enable, error} !== 2'b10) begin
      errs++; $display("FAIL timeout_before cpu/err=%b required 10", {cpu_enable, error});
    end
    @(posedge clk); #1;
    checks++;
    if ({cpu_enable, error, busy} !== 3'b010) begin
      errs++; $display("FAIL timeout_fire cpu/err/busy=%b required 010", {cpu_enable, error, busy});
    end
    do_reset();
`else
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({cpu_enable, error, busy} !== 3'b101) begin
      errs++; $display("FAIL run_persist cpu/err/busy=%b required 101", {cpu_enable, error, busy});
    end
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    checks++;
    if ({done, cpu_enable} !== 2'b10) begin
      errs++; $display("FAIL zero_halt done/cpu=%b required 10", {done, cpu_enable});
    end
`endif
    checks++;
    if (im_a.size() != 0 || dm_a.size() != 0) begin
      errs++; $display("FAIL zero_no_writes imem=%0d dmem=%0d required 0 0", im_a.size(), dm_a.size());
    end
  endtask

  task automatic test_overflow();
    clear_q();
    pulse_start();
    send(32'd513);
    checks++;
    if ({error, s_ready, busy} !== 3'b100) begin
      errs++; $display("FAIL ovf_error err/rdy/busy=%b required 100", {error, s_ready, busy});
    end
    s_data = 32'h5;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({error, cpu_enable, done} !== 3'b100) begin
      errs++; $display("FAIL ovf_sticky err/cpu/done=%b required 100", {error, cpu_enable, done});
    end
    checks++;
    if (im_a.size() != 0 || dm_a.size() != 0) begin
      errs++; $display("FAIL ovf_no_writes imem=%0d dmem=%0d required 0 0", im_a.size(), dm_a.size());
    end
    do_reset();
    checks++;
    if (error !== 1'b0) begin
      errs++; $display("FAIL ovf_reset_exit err=%b required 0", error);
    end
  endtask

  task automatic test_abort();
    clear_q();
    pulse_start();
    send(32'd3);
    send(iw[0]);
    send(iw[1]);
    s_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    checks++;
    if ({imem_wen_ext, imem_addr_ext, imem_wdata_ext, s_ready, busy, cpu_enable} !== '0) begin
      errs++; $display("FAIL abort_async wen=%b addr=%0d data=%h rdy=%b busy=%b required all 0",
                       imem_wen_ext, imem_addr_ext, imem_wdata_ext, s_ready, busy);
    end
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (im_a.size() != 1 || cpu_enable !== 1'b0) begin
      errs++; $display("FAIL abort_no_glitch imem_writes=%0d cpu=%b required 1 0", im_a.size(), cpu_enable);
    end
    clear_q();
    pulse_start();
    send(32'd3);
    for (int i = 0; i < 3; i++) send(iw[i]);
    send(32'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (im_a.size() != 3) begin
      errs++; $display("FAIL abort_reload_count got %0d required 3", im_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (im_a[i] !== 32'(i * 4) || im_d[i] !== iw[i]) begin
          errs++; $display("FAIL abort_reload[%0d] got %h@%0d required %h@%0d", i, im_d[i], im_a[i], iw[i], i * 4);
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_cnt != 0) begin
      errs++; $display("FAIL write_cpu_overlap got %0d required 0", overlap_cnt);
    end
    checks++;
    if (ren_cnt != 0) begin
      errs++; $display("FAIL ren_asserted got %0d required 0", ren_cnt);
    end
  endtask

  initial begin
    iw[0] = 32'hA000_0A00; iw[1] = 32'hA111_1A11; iw[2] = 32'hA222_2A22;
    dw[0] = 32'hB000_0B00; dw[1] = 32'hB111_1B11;
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_headers();
    test_overflow();
    test_abort();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
